regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-side master for the integer register file. It merges single-cycle ALU results with multi-cycle load returns and buffers the loads in a small FIFO. Each load result is byte/halfword-extracted according to its funct3. The block drives the register file write port (regWrite, Addr3, dataIn) from registered outputs. It also exports a pending-load scoreboard so decode can stall on RAW/WAW hazards.

## Interface
Parameters:
- DEPTH, 4, load FIFO entries (power of two, ≥2)
- XLEN, 32, datapath width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; low clears all state
- alu_valid  in  1  ALU result present this cycle (no backpressure)
- alu_rd  in  5  ALU destination register
- alu_result  in  XLEN  ALU result
- load_valid  in  1  load return offered
- load_ready  out  1  FIFO can accept (count < DEPTH)
- load_rd  in  5  load destination register
- load_funct3  in  3  load type (LB/LH/LW/LBU/LHU)
- load_offset  in  2  byte address [1:0] of the load
- load_data  in  XLEN  raw aligned memory word
- regWrite  out  1  write strobe to register file
- Addr3  out  5  write address to register file
- dataIn  out  XLEN  write data to register file
- busy_mask  out  32  bit r set while a load to xr is buffered
- fifo_count  out  $clog2(DEPTH)+1  entries buffered

## Operation
- Load accept: a load is accepted on a rising edge where load_valid && load_ready. The raw word, rd, funct3 and offset are pushed to the FIFO tail.
- load_ready depends only on count; there is no same-cycle pop-through when full.
- Each edge, the write source is selected in this order:
  - alu_valid → write ALU result.
  - else if FIFO non-empty → pop head and write extracted data.
  - else no write.
- ALU always has priority. A continuous ALU stream starves the FIFO; this is acceptable, because load_ready throttles memory.
- rd == 0, either source:
  - The source is consumed: the slot is popped, or the ALU result is dropped.
  - regWrite is 0 for that cycle.
- Extraction, done at pop:
  - 000 LB: byte at offset*8, sign-extended.
  - 001 LH: half at offset[1]*16, sign-extended; offset[0] ignored.
  - 010 LW: full word; offset ignored.
  - 100 LBU, 101 LHU: as LB/LH, zero-extended.
  - Any other funct3: word passed through unmodified.
- busy_mask:
  - OR over valid FIFO entries of onehot(rd); bit 0 is always 0.
  - Derived from registered FIFO state only: set the cycle after the accept edge, cleared the cycle after the pop edge.
- Ordering:
  - Loads retire in acceptance order.
  - ALU vs load to the same rd is not reordered here. Decode must stall on busy_mask[rd] to avoid WAW.
- Simultaneous push and pop on the same edge: both take effect, count unchanged.
- Reset asserted mid-operation: FIFO contents are discarded immediately, and no partial write is emitted.

## Timing
- Reset values: regWrite=0, Addr3=0, dataIn=0, busy_mask=0, fifo_count=0, load_ready=1.
- ALU path: sampled at edge k; regWrite/Addr3/dataIn are valid from edge k until edge k+1. The register file commits at edge k+1.
- Load path, empty FIFO, no ALU traffic: accepted at edge k, popped at edge k+1, outputs valid between edges k+1 and k+2. Minimum latency is 2 edges to the output.
- Outputs are held for exactly one cycle per write; regWrite is never asserted two cycles for one result.
- Full FIFO: load_ready is 0 from the edge count reaches DEPTH. It returns to 1 the cycle after the first pop.
- Throughput: one register write per cycle maximum.

## Test plan
- Reset release, then alu_valid=1, alu_rd=5, alu_result=0x1234 for one cycle → next cycle regWrite=1, Addr3=5, dataIn=0x1234; the following cycle regWrite=0.
- Load LB: rd=7, offset=2, data=0x00800000 → 2 edges later regWrite=1, Addr3=7, dataIn=0xFFFFFF80. Same with LBU → 0x00000080. LH with offset=3 → upper half 0x0080 → 0x00000080.
- Collision: load rd=3 accepted, then alu_valid held 3 cycles to rd=4 → three writes to x4 first, then x3. busy_mask[3]=1 throughout, clearing the cycle the x3 write appears.
- Fill with DEPTH=4 loads while alu_valid=1 continuously → load_ready=0 after the 4th accept, fifo_count=4. Drop alu_valid → four writes in order; load_ready=1 after the first pop.
- rd=0: ALU to x0 and a load to x0 → regWrite stays 0, the FIFO slot frees, busy_mask stays 0.
- Assert reset with 3 buffered loads → fifo_count=0, busy_mask=0, regWrite=0 immediately. After release, no stale writes occur.

Source files
------------

// File: rtl/regfile_writeback.sv
// Register-file write-side arbiter: merges ALU results with buffered load
// returns, extracts sub-word load data at pop time, and exports a scoreboard
// of destinations that still have a load pending.
module regfile_writeback #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_result,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [4:0]               load_rd,
  input  logic [2:0]               load_funct3,
  input  logic [1:0]               load_offset,
  input  logic [XLEN-1:0]          load_data,
  output logic                     regWrite,
  output logic [4:0]               Addr3,
  output logic [XLEN-1:0]          dataIn,
  output logic [31:0]              busy_mask,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] Full = CW'(DEPTH);
  localparam logic [CW-1:0] One  = CW'(1);

  logic [XLEN-1:0]  data_q   [DEPTH];
  logic [4:0]       rd_q     [DEPTH];
  logic [2:0]       f3_q     [DEPTH];
  logic [1:0]       off_q    [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;

  logic             regwrite_q;
  logic [4:0]       addr3_q;
  logic [XLEN-1:0]  datain_q;

  logic             push, pop;
  logic [XLEN-1:0]  load_ext;
  logic [31:0]      busy;

  assign load_ready = (count_q != Full);
  assign push       = load_valid && load_ready;
  // ALU always wins; the FIFO drains only on cycles without an ALU result.
  assign pop        = !alu_valid && (count_q != '0);

  // Load FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        rd_q[i]   <= '0;
        f3_q[i]   <= '0;
        off_q[i]  <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // push and pop never target the same slot: pop needs non-empty, push non-full
      if (push) begin
        data_q[tail_q]  <= load_data;
        rd_q[tail_q]    <= load_rd;
        f3_q[tail_q]    <= load_funct3;
        off_q[tail_q]   <= load_offset;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + One;
      end else if (pop && !push) begin
        count_q <= count_q - One;
      end
    end
  end

  // Byte/halfword extraction of the head entry.
  always_comb begin
    logic [XLEN-1:0] word;
    logic [1:0]      off;
    logic [7:0]      b;
    logic [15:0]     h;
    word     = data_q[head_q];
    off      = off_q[head_q];
    b        = word[{off, 3'b000} +: 8];
    h        = word[{off[1], 4'b0000} +: 16];
    load_ext = word;
    case (f3_q[head_q])
      3'b000:  load_ext = {{(XLEN-8){b[7]}}, b};
      3'b001:  load_ext = {{(XLEN-16){h[15]}}, h};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, b};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, h};
      default: load_ext = word;
    endcase
  end

  // Registered write port; x0 destinations consume their source silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regwrite_q <= 1'b0;
      addr3_q    <= '0;
      datain_q   <= '0;
    end else begin
      regwrite_q <= 1'b0;
      if (alu_valid) begin
        if (alu_rd != 5'd0) begin
          regwrite_q <= 1'b1;
          addr3_q    <= alu_rd;
          datain_q   <= alu_result;
        end
      end else if (pop) begin
        if (rd_q[head_q] != 5'd0) begin
          regwrite_q <= 1'b1;
          addr3_q    <= rd_q[head_q];
          datain_q   <= load_ext;
        end
      end
    end
  end

  // Pending-load scoreboard from registered FIFO state only.
  always_comb begin
    busy = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i]) busy[rd_q[i]] = 1'b1;
    end
    busy[0] = 1'b0;
  end

  assign busy_mask  = busy;
  assign fifo_count = count_q;
  assign regWrite   = regwrite_q;
  assign Addr3      = addr3_q;
  assign dataIn     = datain_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: stimulus pushes expected writes,
// a negedge monitor pops and compares every asserted regWrite.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        load_valid;
  logic        load_ready;
  logic [4:0]  load_rd;
  logic [2:0]  load_funct3;
  logic [1:0]  load_offset;
  logic [31:0] load_data;
  logic        regWrite;
  logic [4:0]  Addr3;
  logic [31:0] dataIn;
  logic [31:0] busy_mask;
  logic [2:0]  fifo_count;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t pend[$];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] data;
    logic [31:0] exp;
  } lvec_t;

  lvec_t lv[10];

  regfile_writeback #(.DEPTH(4), .XLEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_result  (alu_result),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_rd     (load_rd),
    .load_funct3 (load_funct3),
    .load_offset (load_offset),
    .load_data   (load_data),
    .regWrite    (regWrite),
    .Addr3       (Addr3),
    .dataIn      (dataIn),
    .busy_mask   (busy_mask),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid  = v;
    alu_rd     = rd;
    alu_result = d;
    if (v && rd != 5'd0) sb.push_back('{rd: rd, data: d});
  endtask

  task automatic set_load(input logic v, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] off, input logic [31:0] d);
    load_valid  = v;
    load_rd     = rd;
    load_funct3 = f3;
    load_offset = off;
    load_data   = d;
  endtask

  // Monitor: every write must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset === 1'b1 && regWrite === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got x%0d=%h expected no write", Addr3, dataIn);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (Addr3 !== e.rd || dataIn !== e.data) begin
          errors++;
          $display("FAIL write_data: got x%0d=%h expected x%0d=%h", Addr3, dataIn, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    lv[0] = '{rd: 5'd7,  f3: 3'b000, off: 2'd2, data: 32'h0080_0000, exp: 32'hFFFF_FF80};
    lv[1] = '{rd: 5'd7,  f3: 3'b100, off: 2'd2, data: 32'h0080_0000, exp: 32'h0000_0080};
    lv[2] = '{rd: 5'd7,  f3: 3'b001, off: 2'd3, data: 32'h0080_0000, exp: 32'h0000_0080};
    lv[3] = '{rd: 5'd8,  f3: 3'b001, off: 2'd0, data: 32'h1234_8001, exp: 32'hFFFF_8001};
    lv[4] = '{rd: 5'd8,  f3: 3'b101, off: 2'd1, data: 32'h1234_8001, exp: 32'h0000_8001};
    lv[5] = '{rd: 5'd9,  f3: 3'b000, off: 2'd3, data: 32'h8000_0000, exp: 32'hFFFF_FF80};
    lv[6] = '{rd: 5'd9,  f3: 3'b100, off: 2'd1, data: 32'h0000_A500, exp: 32'h0000_00A5};
    lv[7] = '{rd: 5'd10, f3: 3'b010, off: 2'd3, data: 32'hDEAD_BEEF, exp: 32'hDEAD_BEEF};
    lv[8] = '{rd: 5'd10, f3: 3'b011, off: 2'd1, data: 32'hCAFE_F00D, exp: 32'hCAFE_F00D};
    lv[9] = '{rd: 5'd10, f3: 3'b110, off: 2'd2, data: 32'h1234_5678, exp: 32'h1234_5678};

    reset = 1'b0;
    set_alu(1'b0, 5'd0, 32'h0);
    set_load(1'b0, 5'd0, 3'b0, 2'd0, 32'h0);
    #12;
    check("reset_regWrite", {31'h0, regWrite}, 32'h0);
    check("reset_Addr3", {27'h0, Addr3}, 32'h0);
    check("reset_dataIn", dataIn, 32'h0);
    check("reset_busy", busy_mask, 32'h0);
    check("reset_count", {29'h0, fifo_count}, 32'h0);
    check("reset_ready", {31'h0, load_ready}, 32'h1);
    reset = 1'b1;

    // Single ALU write, held for exactly one cycle.
    set_alu(1'b1, 5'd5, 32'h0000_1234);
    tick();
    set_alu(1'b0, 5'd0, 32'h0);
    check("alu_regWrite", {31'h0, regWrite}, 32'h1);
    check("alu_Addr3", {27'h0, Addr3}, 32'd5);
    tick();
    check("alu_one_cycle", {31'h0, regWrite}, 32'h0);

    // Back-to-back loads: push and pop on the same edge keep count at 1.
    for (int i = 0; i < 10; i++) begin
      set_load(1'b1, lv[i].rd, lv[i].f3, lv[i].off, lv[i].data);
      sb.push_back('{rd: lv[i].rd, data: lv[i].exp});
      tick();
      check("load_count", {29'h0, fifo_count}, 32'd1);
      if (i == 0) begin
        check("load_first_no_write", {31'h0, regWrite}, 32'h0);
        check("load_busy_set", busy_mask, 32'h1 << 7);
      end else begin
        check("load_regWrite", {31'h0, regWrite}, 32'h1);
      end
    end
    set_load(1'b0, 5'd0, 3'b0, 2'd0, 32'h0);
    tick();
    check("load_drained", {29'h0, fifo_count}, 32'd0);
    check("load_busy_clear", busy_mask, 32'h0);
    tick();

    // Collision: ALU to x4 for three cycles starves the x3 load.
    set_load(1'b1, 5'd3, 3'b010, 2'd0, 32'h0000_0033);
    pend.push_back('{rd: 5'd3, data: 32'h0000_0033});
    for (int i = 0; i < 3; i++) begin
      set_alu(1'b1, 5'd4, 32'h41 + i);
      tick();
      set_load(1'b0, 5'd0, 3'b0, 2'd0, 32'h0);
      check("coll_busy3", busy_mask, 32'h1 << 3);
      check("coll_addr_x4", {27'h0, Addr3}, 32'd4);
    end
    set_alu(1'b0, 5'd0, 32'h0);
    while (pend.size() != 0) sb.push_back(pend.pop_front());
    tick();
    check("coll_addr_x3", {27'h0, Addr3}, 32'd3);
    check("coll_busy_clear", busy_mask, 32'h0);

    // Fill to DEPTH under continuous ALU traffic, then drain in order.
    for (int i = 0; i < 4; i++) begin
      set_alu(1'b1, 5'd10, 32'hA0 + i);
      set_load(1'b1, 5'(11 + i), 3'b010, 2'd0, 32'h1100 + i);
      pend.push_back('{rd: 5'(11 + i), data: 32'h1100 + i});
      tick();
    end
    check("fill_count", {29'h0, fifo_count}, 32'd4);
    check("fill_ready", {31'h0, load_ready}, 32'h0);
    check("fill_busy", busy_mask, 32'h0000_7800);
    set_alu(1'b1, 5'd10, 32'hA4);
    set_load(1'b1, 5'd15, 3'b010, 2'd0, 32'h1500);
    tick();
    check("full_reject_count", {29'h0, fifo_count}, 32'd4);
    check("full_reject_busy", busy_mask, 32'h0000_7800);
    set_alu(1'b0, 5'd0, 32'h0);
    set_load(1'b0, 5'd0, 3'b0, 2'd0, 32'h0);
    while (pend.size() != 0) sb.push_back(pend.pop_front());
    tick();
    check("drain_first_addr", {27'h0, Addr3}, 32'd11);
    check("drain_count", {29'h0, fifo_count}, 32'd3);
    check("drain_ready", {31'h0, load_ready}, 32'h1);
    check("drain_busy", busy_mask, 32'h0000_7000);
    repeat (3) tick();
    check("drain_empty", {29'h0, fifo_count}, 32'd0);
    tick();

    // x0 destinations: both sources consumed, nothing written.
    set_alu(1'b1, 5'd0, 32'hFFFF_FFFF);
    set_load(1'b1, 5'd0, 3'b010, 2'd0, 32'h0000_00FF);
    tick();
    set_alu(1'b0, 5'd0, 32'h0);
    set_load(1'b0, 5'd0, 3'b0, 2'd0, 32'h0);
    check("x0_alu_nowrite", {31'h0, regWrite}, 32'h0);
    check("x0_count", {29'h0, fifo_count}, 32'd1);
    check("x0_busy", busy_mask, 32'h0);
    tick();
    check("x0_load_nowrite", {31'h0, regWrite}, 32'h0);
    check("x0_freed", {29'h0, fifo_count}, 32'd0);

    // Reset with three buffered loads and a write on the port.
    for (int i = 0; i < 3; i++) begin
      set_alu(1'b1, 5'd0, 32'h0);
      set_load(1'b1, 5'(20 + i), 3'b010, 2'd0, 32'h2000 + i);
      tick();
    end
    check("rst_pre_count", {29'h0, fifo_count}, 32'd3);
    check("rst_pre_busy", busy_mask, 32'h0070_0000);
    set_load(1'b0, 5'd0, 3'b0, 2'd0, 32'h0);
    set_alu(1'b1, 5'd9, 32'h99);
    tick();
    check("rst_pre_write", {31'h0, regWrite}, 32'h1);
    set_alu(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_regWrite", {31'h0, regWrite}, 32'h0);
    check("rst_count", {29'h0, fifo_count}, 32'd0);
    check("rst_busy", busy_mask, 32'h0);
    check("rst_ready", {31'h0, load_ready}, 32'h1);
    tick();
    #2;
    reset = 1'b1;
    repeat (6) tick();
    check("post_rst_nowrite", {31'h0, regWrite}, 32'h0);
    check("post_rst_count", {29'h0, fifo_count}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
